pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/return_stack.sv | 96 +++++++++
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencer: the flow-operation
// encodings driven on pc_op and the default reset / interrupt vectors.
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_SEQ     = 3'd0,
        OP_SKIP    = 3'd1,
        OP_GOTO    = 3'd2,
        OP_CALL    = 3'd3,
        OP_RETURN  = 3'd4,
        OP_RETFIE  = 3'd5,
        OP_LOADPCL = 3'd6,
        OP_RSVD    = 3'd7
    } pc_op_e;

    localparam logic [12:0] PC_RESET_VECTOR = 13'h0000;
    localparam logic [12:0] PC_ISR_VECTOR   = 13'h0004;

endpackage

// File: rtl/return_stack.sv
// -----------------------------------------------------------------------------
// return_stack
// Circular hardware return stack. A push writes the slot at sp and advances
// sp; a pop retreats sp and presents the slot below the old sp. When the stack
// is full a push overwrites the oldest entry; when it is empty a pop returns
// whatever entry the pointer wraps onto. Both cases raise sticky flags.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   push, pop  : stack operations for this cycle (never both at once)
//   push_data  : value written on push
//   pop_data   : value returned by a pop issued this cycle (combinational)
//   ovf, unf   : sticky overflow / underflow flags
// -----------------------------------------------------------------------------
module return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             ovf,
    output logic             unf
);

    localparam int SP_W  = $clog2(DEPTH);
    localparam int CNT_W = SP_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [SP_W-1:0]  sp_q,    sp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;

    logic full;
    logic empty;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem[sp_q - SP_W'(1)];
    assign ovf      = ovf_q;
    assign unf      = unf_q;

    // NOTE: every signal assigned here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push) begin
            sp_d = sp_q + SP_W'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            sp_d = sp_q - SP_W'(1);
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: the storage array deliberately has no reset; only the pointer and
    // occupancy define which entries are meaningful, and this maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for a PIC-style core. Each unstalled cycle it
// selects the next pc from pc_op (or the interrupt vector when irq is
// accepted), drives the return stack, and squashes the instructions already
// in flight in program memory after any change of flow.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   stall        : freeze all state this cycle
//   pc_op        : flow operation (pc_op_e encoding)
//   target       : goto/call literal; [7:0] is the new PCL for LOADPCL
//   pclath       : PCLATH register value
//   irq          : interrupt accepted at this instruction boundary
//   pm_addr      : program-memory fetch address (= pc)
//   pm_rd_en     : program-memory read enable (= ~stall)
//   pm_flush     : squash the program-memory instruction register
//   pc           : current program counter
//   retfie_pulse : one-cycle pulse after an executed RETFIE
//   stk_ovf/unf  : sticky return-stack overflow / underflow
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 13,
    parameter int                    STACK_DEPTH  = 8,
    parameter int                    FLUSH_CYCLES = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(PC_RESET_VECTOR),
    parameter logic [ADDR_WIDTH-1:0] ISR_VECTOR   = ADDR_WIDTH'(PC_ISR_VECTOR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [2:0]            pc_op,
    input  logic [10:0]           target,
    input  logic [4:0]            pclath,
    input  logic                  irq,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic                  pm_rd_en,
    output logic                  pm_flush,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  retfie_pulse,
    output logic                  stk_ovf,
    output logic                  stk_unf
);

    localparam int FC_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    logic [ADDR_WIDTH-1:0] pc_q,        pc_d;
    logic [FC_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                  pm_flush_q,  pm_flush_d;
    logic                  retfie_q,    retfie_d;

    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] push_data;
    logic [ADDR_WIDTH-1:0] pop_data;
    logic                  flush_start;

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] goto_addr;
    logic [ADDR_WIDTH-1:0] loadpcl_addr;
    pc_op_e                op;

    // Increments wrap naturally at the address width.
    assign pc_inc       = pc_q + ADDR_WIDTH'(1);
    assign goto_addr    = ADDR_WIDTH'({pclath[4:3], target});
    assign loadpcl_addr = ADDR_WIDTH'({pclath, target[7:0]});
    assign op           = pc_op_e'(pc_op);

    always_comb begin
        pc_d        = pc_q;
        flush_cnt_d = flush_cnt_q;
        retfie_d    = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        push_data   = pc_inc;
        flush_start = 1'b0;

        if (!stall) begin
            pc_d = pc_inc;
            if (flush_cnt_q != '0) begin
                flush_cnt_d = flush_cnt_q - FC_W'(1);
            end

            // An accepted interrupt replaces this cycle's flow operation and
            // saves the address of the instruction it preempted.
            if (irq) begin
                push        = 1'b1;
                push_data   = pc_q;
                pc_d        = ISR_VECTOR;
                flush_start = 1'b1;
            end else begin
                unique case (op)
                    OP_SKIP: begin
                        pc_d        = pc_q + ADDR_WIDTH'(2);
                        flush_start = 1'b1;
                    end
                    OP_GOTO: begin
                        pc_d        = goto_addr;
                        flush_start = 1'b1;
                    end
                    OP_CALL: begin
                        push        = 1'b1;
                        pc_d        = goto_addr;
                        flush_start = 1'b1;
                    end
                    OP_RETURN: begin
                        pop         = 1'b1;
                        pc_d        = pop_data;
                        flush_start = 1'b1;
                    end
                    OP_RETFIE: begin
                        pop         = 1'b1;
                        pc_d        = pop_data;
                        flush_start = 1'b1;
                        retfie_d    = 1'b1;
                    end
                    OP_LOADPCL: begin
                        pc_d        = loadpcl_addr;
                        flush_start = 1'b1;
                    end
                    OP_SEQ, OP_RSVD: begin
                        pc_d = pc_inc;
                    end
                    default: begin
                        pc_d = pc_inc;
                    end
                endcase
            end

            // A new change of flow restarts the squash window rather than
            // extending it.
            if (flush_start) begin
                flush_cnt_d = FC_W'(FLUSH_CYCLES);
            end
        end

        pm_flush_d = (flush_cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            flush_cnt_q <= '0;
            pm_flush_q  <= 1'b0;
            retfie_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
            pm_flush_q  <= pm_flush_d;
            retfie_q    <= retfie_d;
        end
    end

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_return_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .pop_data  (pop_data),
        .ovf       (stk_ovf),
        .unf       (stk_unf)
    );

    assign pc           = pc_q;
    assign pm_addr      = pc_q;
    assign pm_rd_en     = ~stall;
    assign pm_flush     = pm_flush_q;
    assign retfie_pulse = retfie_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer: each scenario task drives the sequencer
// and compares its outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  pc_op;
    logic [10:0] target;
    logic [4:0]  pclath;
    logic        irq;
    logic [12:0] pm_addr;
    logic        pm_rd_en;
    logic        pm_flush;
    logic [12:0] pc;
    logic        retfie_pulse;
    logic        stk_ovf;
    logic        stk_unf;

    int checks;
    int errors;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .pc_op        (pc_op),
        .target       (target),
        .pclath       (pclath),
        .irq          (irq),
        .pm_addr      (pm_addr),
        .pm_rd_en     (pm_rd_en),
        .pm_flush     (pm_flush),
        .pc           (pc),
        .retfie_pulse (retfie_pulse),
        .stk_ovf      (stk_ovf),
        .stk_unf      (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operation across one rising edge, then sample 1 ns later.
    task automatic step(input logic [2:0] op, input logic [10:0] tgt);
        pc_op  = op;
        target = tgt;
        @(posedge clk);
        #1;
        pc_op  = OP_SEQ;
        target = '0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        stall  = 1'b0;
        irq    = 1'b0;
        pc_op  = OP_SEQ;
        target = '0;
        pclath = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== 13'h0000 || pm_flush !== 1'b0 || retfie_pulse !== 1'b0 ||
            stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h flush=%b retfie=%b ovf=%b unf=%b expected pc=0000 others 0",
                     pc, pm_flush, retfie_pulse, stk_ovf, stk_unf);
        end
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(OP_SEQ, '0);
            checks++;
            if (pc !== 13'(i) || pm_flush !== 1'b0 || pm_addr !== 13'(i)) begin
                errors++;
                $display("FAIL seq_%0d: pc=%h addr=%h flush=%b expected pc=%h flush=0",
                         i, pc, pm_addr, pm_flush, 13'(i));
            end
        end
    endtask

    task automatic test_call_return();
        logic [1:0] seen;
        do_reset();
        step(OP_GOTO, 11'h00E);
        step(OP_SEQ, '0);
        step(OP_SEQ, '0);
        checks++;
        if (pc !== 13'h0010 || pm_flush !== 1'b0) begin
            errors++;
            $display("FAIL call_setup: pc=%h flush=%b expected pc=0010 flush=0", pc, pm_flush);
        end
        pclath = 5'b11000;
        step(OP_CALL, 11'h123);
        checks++;
        if (pc !== 13'h1923 || pm_flush !== 1'b1) begin
            errors++;
            $display("FAIL call_target: pc=%h flush=%b expected pc=1923 flush=1", pc, pm_flush);
        end
        pclath = '0;
        seen[0] = pm_flush;
        step(OP_SEQ, '0);
        seen[1] = pm_flush;
        step(OP_SEQ, '0);
        checks++;
        if (seen !== 2'b11 || pm_flush !== 1'b0 || pc !== 13'h1925) begin
            errors++;
            $display("FAIL call_flush_len: flush seq=%b%b then %b pc=%h expected 11 then 0 pc=1925",
                     seen[0], seen[1], pm_flush, pc);
        end
        step(OP_RETURN, '0);
        checks++;
        if (pc !== 13'h0011 || pm_flush !== 1'b1) begin
            errors++;
            $display("FAIL return_addr: pc=%h flush=%b expected pc=0011 flush=1", pc, pm_flush);
        end
    endtask

    task automatic test_stack_wrap();
        logic [12:0] exp_pop [9];
        do_reset();
        // Call k targets 0x100+16k; pushes are 0x001, 0x101 .. 0x171, the
        // ninth overwriting the oldest slot.
        for (int k = 0; k < 9; k++) begin
            step(OP_CALL, 11'(11'h100 + 11'(k * 16)));
            if (k == 7) begin
                checks++;
                if (stk_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: ovf=%b after 8 calls expected 0", stk_ovf);
                end
            end
        end
        checks++;
        if (stk_ovf !== 1'b1 || pc !== 13'h0180) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b pc=%h expected ovf=1 pc=0180", stk_ovf, pc);
        end
        exp_pop = '{13'h171, 13'h161, 13'h151, 13'h141, 13'h131,
                    13'h121, 13'h111, 13'h101, 13'h171};
        for (int r = 0; r < 9; r++) begin
            step(OP_RETURN, '0);
            checks++;
            if (pc !== exp_pop[r]) begin
                errors++;
                $display("FAIL pop_%0d: pc=%h expected %h", r, pc, exp_pop[r]);
            end
            if (r == 7) begin
                checks++;
                if (stk_unf !== 1'b0) begin
                    errors++;
                    $display("FAIL unf_early: unf=%b after 8 returns expected 0", stk_unf);
                end
            end
        end
        checks++;
        if (stk_unf !== 1'b1) begin
            errors++;
            $display("FAIL unf_set: unf=%b expected 1", stk_unf);
        end
    endtask

    task automatic test_irq_retfie();
        do_reset();
        step(OP_GOTO, 11'h020);
        irq = 1'b1;
        step(OP_GOTO, 11'h555);
        irq = 1'b0;
        checks++;
        if (pc !== 13'h0004 || pm_flush !== 1'b1 || retfie_pulse !== 1'b0) begin
            errors++;
            $display("FAIL irq_vector: pc=%h flush=%b retfie=%b expected pc=0004 flush=1 retfie=0",
                     pc, pm_flush, retfie_pulse);
        end
        step(OP_RETFIE, '0);
        checks++;
        if (pc !== 13'h0020 || retfie_pulse !== 1'b1) begin
            errors++;
            $display("FAIL retfie: pc=%h retfie=%b expected pc=0020 retfie=1", pc, retfie_pulse);
        end
        step(OP_SEQ, '0);
        checks++;
        if (pc !== 13'h0021 || retfie_pulse !== 1'b0) begin
            errors++;
            $display("FAIL retfie_pulse_len: pc=%h retfie=%b expected pc=0021 retfie=0",
                     pc, retfie_pulse);
        end
    endtask

    task automatic test_stall_and_wrap();
        do_reset();
        step(OP_GOTO, 11'h050);
        stall = 1'b1;
        irq   = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (pm_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_rd_en_%0d: rd_en=%b expected 0", s, pm_rd_en);
            end
            step(OP_CALL, 11'h3FF);
            checks++;
            if (pc !== 13'h0050 || pm_flush !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d: pc=%h flush=%b expected pc=0050 flush=1",
                         s, pc, pm_flush);
            end
        end
        stall = 1'b0;
        irq   = 1'b0;
        step(OP_SEQ, '0);
        checks++;
        if (pc !== 13'h0051 || pm_flush !== 1'b1 || pm_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: pc=%h flush=%b rd_en=%b expected pc=0051 flush=1 rd_en=1",
                     pc, pm_flush, pm_rd_en);
        end
        step(OP_SEQ, '0);
        checks++;
        if (pc !== 13'h0052 || pm_flush !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush_done: pc=%h flush=%b expected pc=0052 flush=0", pc, pm_flush);
        end

        pclath = 5'b11111;
        step(OP_LOADPCL, 11'h7FF);
        checks++;
        if (pc !== 13'h1FFF) begin
            errors++;
            $display("FAIL loadpcl: pc=%h expected 1fff", pc);
        end
        step(OP_SEQ, '0);
        checks++;
        if (pc !== 13'h0000) begin
            errors++;
            $display("FAIL seq_wrap: pc=%h expected 0000", pc);
        end
        step(OP_LOADPCL, 11'h0FE);
        step(OP_SKIP, '0);
        checks++;
        if (pc !== 13'h0000 || pm_flush !== 1'b1) begin
            errors++;
            $display("FAIL skip_wrap: pc=%h flush=%b expected pc=0000 flush=1", pc, pm_flush);
        end
        pclath = '0;
        step(OP_RSVD, 11'h2AA);
        checks++;
        if (pc !== 13'h0001) begin
            errors++;
            $display("FAIL reserved_op: pc=%h expected 0001", pc);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        step(OP_CALL, 11'h100);
        step(OP_RETFIE, '0);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== 13'h0000 || pm_flush !== 1'b0 || retfie_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pc=%h flush=%b retfie=%b expected pc=0000 flush=0 retfie=0",
                     pc, pm_flush, retfie_pulse);
        end
        #2;
        rst = 1'b0;
        step(OP_SEQ, '0);
        checks++;
        if (pc !== 13'h0001 || pm_flush !== 1'b0 || retfie_pulse !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: pc=%h flush=%b retfie=%b expected pc=0001 flush=0 retfie=0",
                     pc, pm_flush, retfie_pulse);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        stall  = 1'b0;
        irq    = 1'b0;
        pc_op  = OP_SEQ;
        target = '0;
        pclath = '0;
        test_reset();
        test_call_return();
        test_stack_wrap();
        test_irq_retfie();
        test_stall_and_wrap();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
